// File: rtl/unum_mm_pkg.sv
// Shared constants and FSM state encodings for the unum matrix-multiply scheduler.
package unum_mm_pkg;

    localparam int DEF_AW      = 12;
    localparam int DEF_DW      = 6;
    localparam int DEF_CREDITS = 4;
    localparam int DEF_CW      = 3;

    // Multiplier input register to finish_o; the scheduler never relies on it.
    localparam int MUL_LATENCY = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLR   = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

endpackage

// File: rtl/unum_mm_credit_ctr.sv
// Saturating up/down counter with a reset value; simultaneous inc and dec cancel.
module unum_mm_credit_ctr #(
    parameter int             W       = 3,
    parameter logic [W-1:0]   INIT    = '0,
    parameter logic [W-1:0]   MAX_VAL = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= INIT;
        end else if (inc && !dec && count != MAX_VAL) begin
            count <= count + W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/unum_mm_scheduler.sv
// Operand-read sequencer for one C = A * B job: walks i/j/k, issues buffer reads,
// strobes the multiplier and throttles dot products against downstream credits.
module unum_mm_scheduler
    import unum_mm_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int CREDITS = DEF_CREDITS,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dim_m,
    input  logic [DW-1:0] dim_n,
    input  logic [DW-1:0] dim_k,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mul_valid,
    output logic          mul_finish,
    output logic          mul_rst,
    input  logic          res_finish,
    input  logic          credit_ret,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic [DW-1:0] m_q, n_q, k_q;
    logic [DW-1:0] i_cnt, j_cnt, k_cnt;
    logic [AW-1:0] a_base, b_base;
    logic [AW-1:0] k_step;
    logic [CW-1:0] credit, outstanding;
    logic          issue, k_first, k_last, j_last, i_last, dims_zero;

    assign k_first   = (k_cnt == '0);
    assign k_last    = (k_cnt == k_q - DW'(1));
    assign j_last    = (j_cnt == n_q - DW'(1));
    assign i_last    = (i_cnt == m_q - DW'(1));
    assign dims_zero = (dim_m == '0) || (dim_n == '0) || (dim_k == '0);
    assign k_step    = AW'(k_q);

    // Only the first pair of a dot product waits for a credit; the rest stream through.
    assign issue   = (state == ST_ISSUE) && (!k_first || credit != '0);
    assign rd_en   = issue;
    assign mul_rst = (state == ST_CLR);
    assign a_addr  = a_base + AW'(k_cnt);
    assign b_addr  = b_base + AW'(k_cnt);

    unum_mm_credit_ctr #(
        .W       (CW),
        .INIT    (CW'(CREDITS)),
        .MAX_VAL (CW'(CREDITS))
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .inc   (credit_ret),
        .dec   (issue && k_first),
        .count (credit)
    );

    unum_mm_credit_ctr #(
        .W       (CW),
        .INIT    ('0),
        .MAX_VAL ({CW{1'b1}})
    ) u_outstanding (
        .clk   (clk),
        .rst   (rst),
        .inc   (issue && k_last),
        .dec   (res_finish),
        .count (outstanding)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mul_valid  <= 1'b0;
            mul_finish <= 1'b0;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            k_cnt      <= '0;
            a_base     <= '0;
            b_base     <= '0;
        end else begin
            done       <= 1'b0;
            mul_valid  <= issue;
            mul_finish <= issue && k_last;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_q   <= dim_m;
                        n_q   <= dim_n;
                        k_q   <= dim_k;
                        busy  <= 1'b1;
                        state <= dims_zero ? ST_FIN : ST_CLR;
                    end
                end
                ST_CLR: state <= ST_ISSUE;
                ST_ISSUE: begin
                    if (issue) begin
                        if (!k_last) begin
                            k_cnt <= k_cnt + DW'(1);
                        end else begin
                            k_cnt <= '0;
                            if (!j_last) begin
                                j_cnt  <= j_cnt + DW'(1);
                                b_base <= b_base + k_step;
                            end else begin
                                // Row done: B restarts at column 0, A moves to the next row.
                                j_cnt  <= '0;
                                b_base <= '0;
                                if (!i_last) begin
                                    i_cnt  <= i_cnt + DW'(1);
                                    a_base <= a_base + k_step;
                                end else begin
                                    i_cnt  <= '0;
                                    a_base <= '0;
                                    state  <= ST_DRAIN;
                                end
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == '0 && !mul_valid) state <= ST_FIN;
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unum_mm_scheduler.sv
// Directed bench for unum_mm_scheduler with a fixed-latency datapath model that
// returns res_finish roughly MUL_LATENCY cycles after each mul_finish.
module tb_unum_mm_scheduler;
    import unum_mm_pkg::*;

    logic        clk, rst, start;
    logic [5:0]  dim_m, dim_n, dim_k;
    logic        rd_en, mul_valid, mul_finish, mul_rst;
    logic [11:0] a_addr, b_addr;
    logic        res_finish, credit_ret, busy, done;

    int total = 0;
    int bad   = 0;

    unum_mm_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dim_m      (dim_m),
        .dim_n      (dim_n),
        .dim_k      (dim_k),
        .rd_en      (rd_en),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .mul_valid  (mul_valid),
        .mul_finish (mul_finish),
        .mul_rst    (mul_rst),
        .res_finish (res_finish),
        .credit_ret (credit_ret),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: delay line on mul_finish, updated just after each rising edge.
    logic [MUL_LATENCY-1:0] fin_pipe;
    initial begin
        fin_pipe   = '0;
        res_finish = 1'b0;
    end
    always @(posedge clk) begin
        #1;
        if (rst) fin_pipe = '0;
        else     fin_pipe = {fin_pipe[MUL_LATENCY-2:0], mul_finish};
        res_finish = fin_pipe[MUL_LATENCY-1];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        fin;
    } pair_t;

    pair_t vec[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        credit_ret = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_job(input int m, input int n, input int k);
        dim_m = 6'(m);
        dim_n = 6'(n);
        dim_k = 6'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},      rd_en,      0);
        check({tag, "_mul_valid"},  mul_valid,  0);
        check({tag, "_mul_finish"}, mul_finish, 0);
        check({tag, "_mul_rst"},    mul_rst,    0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_a_addr"},     a_addr,     0);
        check({tag, "_b_addr"},     b_addr,     0);
    endtask

    initial begin
        int a_seq[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
        int b_seq[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
        int f_seq[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        int dones, rds, first, last, b_first;
        bit ret_seen, early;

        for (int p = 0; p < 12; p++) begin
            vec[p].a   = 12'(a_seq[p]);
            vec[p].b   = 12'(b_seq[p]);
            vec[p].fin = f_seq[p][0];
        end

        dim_m = '0;
        dim_n = '0;
        dim_k = '0;
        tick();

        // Reset state
        do_reset();
        check_all_zero("reset");

        // 1x1x1 job
        start_job(1, 1, 1);
        check("t1_clr_mul_rst", mul_rst, 1);
        check("t1_clr_rd_en",   rd_en,   0);
        check("t1_clr_valid",   mul_valid, 0);
        check("t1_busy",        busy,    1);
        tick();
        check("t1_rd_en",   rd_en,   1);
        check("t1_a_addr",  a_addr,  0);
        check("t1_b_addr",  b_addr,  0);
        check("t1_mul_rst", mul_rst, 0);
        tick();
        check("t1_mul_valid",  mul_valid,  1);
        check("t1_mul_finish", mul_finish, 1);
        check("t1_rd_en_off",  rd_en,      0);
        dones = 0; rds = 0; ret_seen = 0; early = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_finish) ret_seen = 1;
            if (done) begin
                dones++;
                if (!ret_seen) early = 1;
            end
            if (rd_en) rds++;
            tick();
        end
        check("t1_done_count", dones, 1);
        check("t1_done_early", early, 0);
        check("t1_extra_rd",   rds,   0);
        check("t1_busy_end",   busy,  0);

        // 2x2x3 job, credits returned alongside each dot-product start, stray start mid-job
        do_reset();
        start_job(2, 2, 3);
        tick();
        for (int p = 0; p < 12; p++) begin
            check($sformatf("t2_rd_en[%0d]", p),  rd_en,  1);
            check($sformatf("t2_a_addr[%0d]", p), a_addr, vec[p].a);
            check($sformatf("t2_b_addr[%0d]", p), b_addr, vec[p].b);
            if (p > 0) begin
                check($sformatf("t2_valid[%0d]", p - 1),  mul_valid,  1);
                check($sformatf("t2_finish[%0d]", p - 1), mul_finish, vec[p - 1].fin);
            end
            credit_ret = (p % 3 == 0);
            start      = (p == 5);
            tick();
            credit_ret = 1'b0;
            start      = 1'b0;
        end
        check("t2_rd_en_after",  rd_en,      0);
        check("t2_valid[11]",    mul_valid,  1);
        check("t2_finish[11]",   mul_finish, vec[11].fin);
        dones = 0; rds = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) dones++;
            if (rd_en) rds++;
            tick();
        end
        check("t2_done_count", dones, 1);
        check("t2_extra_rd",   rds,   0);

        // 1x6x2 job: credit_ret coincident with the 4th start at credit 1, then a stall
        do_reset();
        start_job(1, 6, 2);
        rds = 0; first = -1; last = -1;
        for (int c = 0; c < 30 && rds < 10; c++) begin
            credit_ret = rd_en && a_addr == 12'd0 && b_addr == 12'd6;
            if (rd_en) begin
                if (first < 0) first = c;
                last = c;
                rds++;
            end
            tick();
            credit_ret = 1'b0;
        end
        check("t3_pairs_before_stall", rds, 10);
        check("t3_no_bubble_span", last - first, 9);
        rds = 0;
        for (int c = 0; c < 12; c++) begin
            if (rd_en) rds++;
            tick();
        end
        check("t3_stall_rd", rds, 0);
        check("t3_stall_busy", busy, 1);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        rds = 0; b_first = -1;
        for (int c = 0; c < 6; c++) begin
            if (rd_en) begin
                if (b_first < 0) b_first = int'(b_addr);
                rds++;
            end
            tick();
        end
        check("t3_resume_rd", rds, 2);
        check("t3_resume_b_addr", b_first, 10);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dones++;
            tick();
        end
        check("t3_done_count", dones, 1);

        // Zero-length dimension: straight to FIN
        do_reset();
        start_job(2, 2, 0);
        check("t4_busy",     busy,    1);
        check("t4_done_c1",  done,    0);
        check("t4_mul_rst",  mul_rst, 0);
        check("t4_rd_en",    rd_en,   0);
        tick();
        check("t4_done_c2",  done,    1);
        check("t4_busy_c2",  busy,    0);
        check("t4_rd_en_c2", rd_en,   0);
        check("t4_rst_c2",   mul_rst, 0);
        tick();
        check("t4_done_c3",  done,    0);

        // Reset in the middle of ISSUE, then a fresh job sees a full credit pool
        do_reset();
        start_job(3, 3, 3);
        tick();
        for (int c = 0; c < 5; c++) tick();
        check("t5_pre_rst_rd_en", rd_en, 1);
        rst = 1'b1;
        tick();
        check_all_zero("t5_abort");
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) dones++;
            tick();
        end
        check("t5_no_done", dones, 0);
        start_job(1, 5, 1);
        rds = 0;
        for (int c = 0; c < 15; c++) begin
            if (rd_en) rds++;
            tick();
        end
        check("t5_credit_limited_rd", rds, 4);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        rds = 0; dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (rd_en) rds++;
            if (done) dones++;
            tick();
        end
        check("t5_last_rd",    rds,   1);
        check("t5_done_count", dones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unum_mm_scheduler.md
Name: unum_mm_scheduler

Overview:
- Sequences operand reads for one matrix-multiply job (C[MxN] = A[MxK] * B[KxN]) and feeds the pipelined unum multiplier/CSA datapath.
- Generates A/B buffer read addresses, multiplier valid/finish/rst strobes, and per-dot-product credits against the downstream accumulator/result FIFO.
- Tracks in-flight dot products and signals job completion when the last finish returns from the datapath.

Parameters:
- AW, 12, operand buffer address width.
- DW, 6, width of each dimension field (M, N, K); 0 is illegal as a length.
- CREDITS, 4, downstream result slots; also the reset value of the credit counter.
- CW, 3, width of credit and outstanding counters; must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- dim_m  in  DW  rows of A; sampled on accepted start.
- dim_n  in  DW  columns of B; sampled on accepted start.
- dim_k  in  DW  dot-product length; sampled on accepted start.
- rd_en  out  1  operand buffer read strobe.
- a_addr  out  AW  A address (row-major, i*K+k).
- b_addr  out  AW  B address (column-major, j*K+k).
- mul_valid  out  1  to multiplier valid; 1 cycle after rd_en (buffer read latency 1).
- mul_finish  out  1  to multiplier finish_in; marks the last pair of a dot product; aligned with mul_valid.
- mul_rst  out  1  to multiplier rst (pipelined accumulator clear).
- res_finish  in  1  finish_o returned from the datapath, one pulse per completed dot product.
- credit_ret  in  1  downstream frees one result slot.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state IDLE; rd_en, mul_valid, mul_finish, mul_rst, busy and done are 0. a_addr and b_addr are 0. credit = CREDITS. outstanding = 0. All loop counters are 0.
- Reset mid-job aborts the job with no done pulse. Results still in the datapath are discarded downstream by the mul_rst/rst path.
- States: IDLE, CLR, ISSUE, DRAIN, FIN.
  - IDLE: on start, latch dims, go to CLR, set busy. If any latched dim is 0, go directly to FIN.
  - CLR: one cycle with mul_rst=1 and mul_valid=0, then ISSUE.
  - ISSUE: nested loops i<M, j<N, k<K, with k innermost.
  - A dot product may begin (k==0) only when credit>0. The credit is consumed on that cycle. k>0 issues never stall.
  - If credit==0 at k==0, rd_en=0 and the counters hold (a bubble).
  - Each issue cycle: rd_en=1. The delayed mul_valid is 1 on the next cycle; the delayed mul_finish is 1 on the next cycle if k==K-1.
  - After the issue of i=M-1, j=N-1, k=K-1, go to DRAIN.
  - DRAIN: wait until outstanding==0 and the final mul_valid has been emitted, then FIN.
  - FIN: done=1 for one cycle, busy=0, back to IDLE.
- Address generation uses no multiplier:
  - a_base and b_base hold the start address of the current A row and B column.
  - a_addr = a_base + k and b_addr = b_base + k.
  - At the end of a dot product, b_base += K. At the end of a row, b_base = 0 and a_base += K.
  - Addresses wrap modulo 2^AW. The bench does not exercise M*K or K*N > 2^AW.
- Credits:
  - +1 on credit_ret, -1 on a k==0 issue. Both in the same cycle leaves the counter unchanged.
  - credit_ret arriving with credit==CREDITS saturates the counter and is ignored.
- Outstanding:
  - +1 on a finish issue, -1 on res_finish. Both in the same cycle leaves the counter unchanged.
  - res_finish when outstanding==0 is ignored.
- start while busy is ignored. Dims are stable for the whole job.
- Throughput: 1 pair/cycle when credits are available. Total issue cycles = M*N*K plus credit bubbles.

Decomposition:
- Shared package unum_mm_pkg holds:
  - the state enum;
  - MUL_LATENCY = 8 (input register to finish_o), used by the bench only;
  - default AW/DW/CREDITS constants.
- One natural sub-module, unum_mm_credit_ctr: a saturating up/down counter with init value. Instantiate it twice, once for credit and once for outstanding.

Test Plan:
- M=N=K=1, CREDITS=4, datapath model returns res_finish 8 cycles after mul_finish -> one rd_en with a_addr=0/b_addr=0; mul_rst exactly one cycle before the first rd_en; done pulses once after res_finish returns.
- M=2, N=2, K=3, credit_ret returned immediately -> 12 consecutive rd_en cycles. a_addr sequence is 0,1,2,0,1,2,3,4,5,3,4,5. b_addr sequence is 0,1,2,3,4,5,0,1,2,3,4,5. mul_finish occurs on pairs 3, 6, 9 and 12.
- CREDITS=2, M=1, N=4, K=2, no credit_ret until cycle 20 -> issues stop after 4 pairs; rd_en stays 0 until credit_ret; the remaining 4 pairs issue afterwards.
- credit_ret coincident with a k==0 issue while credit==1 -> credit stays 1 and the next dot product issues without a bubble.
- dim_k=0 on start -> no rd_en, no mul_rst, done pulses 2 cycles after start, busy low again after done.
- rst asserted in ISSUE after 5 pairs -> the next cycle shows all outputs 0, credit=CREDITS and no done; a new start then runs normally.
